lock_in_demod_acc: RTL and testbench

LOCK_IN_DEMOD_ACC -- requirements
Module: lock_in_demod_acc

---
 rtl/lock_pkg.sv | 23 ++
 rtl/lock_sat_shift.sv | 38 +++
 rtl/lock_in_demod_acc.sv | 176 +++++++++++++++++
 tb/tb_lock_in_demod_acc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the lock-in demodulator accumulator.
// Holds the sample/product widths, default accumulator and counter widths,
// the dump shift limits and the FSM state encoding.
package lock_pkg;

  localparam int unsigned SAMP_W    = 14;
  localparam int unsigned PROD_W    = 2 * SAMP_W;
  localparam int unsigned ACC_W_DEF = 48;
  localparam int unsigned CNT_W_DEF = 24;
  localparam int unsigned PER_W     = 8;
  localparam int unsigned SHIFT_W   = 6;
  localparam int unsigned MAX_SHIFT = 47;

  localparam logic signed [SAMP_W-1:0] OUT_MAX = 14'sd8191;
  localparam logic signed [SAMP_W-1:0] OUT_MIN = -14'sd8192;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

endpackage

// File: rtl/lock_sat_shift.sv
// Arithmetic right shift of an ACC_W-bit signed sum followed by saturation
// to a 14-bit signed output.
//   din   : signed window sum
//   shift : right-shift amount, clamped to MAX_SHIFT
//   dout  : shifted, saturated result in [-8192, 8191]
//   clip  : high when dout was clamped to a rail
module lock_sat_shift
  import lock_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]   din,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [SAMP_W-1:0]  dout,
  output logic                      clip
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(OUT_MIN);

  logic        [SHIFT_W-1:0] sh;
  logic signed [ACC_W-1:0]   shifted;

  always_comb begin
    sh      = (shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift;
    shifted = din >>> sh;
    clip    = 1'b0;
    dout    = shifted[SAMP_W-1:0];
    if (shifted > HI) begin
      dout = OUT_MAX;
      clip = 1'b1;
    end else if (shifted < LO) begin
      dout = OUT_MIN;
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/lock_in_demod_acc.sv
// Lock-in demodulator: multiplies the ADC sample by in-phase and quadrature
// references and integrates the products over a window of n_periods
// reference periods delimited by harmonic_trig.
//   clk, rstn       : clock, synchronous active-low reset
//   en              : enable; low returns the block to idle
//   sig_in          : signed ADC sample
//   ref_x, ref_y    : signed in-phase / quadrature references
//   harmonic_trig   : high on the last sample of each reference period
//   n_periods       : periods per window (0 behaves as 1)
//   shift           : right shift applied to the sums at dump
//   x_out, y_out    : scaled, saturated window sums
//   x_sum, y_sum    : raw window sums
//   samp_cnt        : samples in the last window
//   out_valid       : one-cycle strobe when the outputs update
//   sat_flag        : last window saturated the counter or an output
module lock_in_demod_acc
  import lock_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic signed [SAMP_W-1:0]  sig_in,
  input  logic signed [SAMP_W-1:0]  ref_x,
  input  logic signed [SAMP_W-1:0]  ref_y,
  input  logic                      harmonic_trig,
  input  logic        [PER_W-1:0]   n_periods,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [SAMP_W-1:0]  x_out,
  output logic signed [SAMP_W-1:0]  y_out,
  output logic signed [ACC_W-1:0]   x_sum,
  output logic signed [ACC_W-1:0]   y_sum,
  output logic        [CNT_W-1:0]   samp_cnt,
  output logic                      out_valid,
  output logic                      sat_flag
);

  logic signed [SAMP_W-1:0]  s1_sig, s1_rx, s1_ry;
  logic                      s1_trig;
  logic signed [PROD_W-1:0]  px, py;
  logic                      s2_trig;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc_x, acc_y, sum_x, sum_y;
  logic        [CNT_W-1:0]   cnt, cnt_next;
  logic                      cnt_ovf, cnt_ovf_next;
  logic        [PER_W-1:0]   per, n_lat;
  logic        [PER_W:0]     per_next;
  logic        [SHIFT_W-1:0] sh_lat;
  logic                      window_done;
  logic signed [SAMP_W-1:0]  qx, qy;
  logic                      clip_x, clip_y;

  // Stages 1 and 2: input registers, then full-precision products.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_sig  <= '0;
      s1_rx   <= '0;
      s1_ry   <= '0;
      s1_trig <= 1'b0;
      px      <= '0;
      py      <= '0;
      s2_trig <= 1'b0;
    end else begin
      s1_sig  <= sig_in;
      s1_rx   <= ref_x;
      s1_ry   <= ref_y;
      s1_trig <= harmonic_trig;
      px      <= s1_sig * s1_rx;
      py      <= s1_sig * s1_ry;
      s2_trig <= s1_trig;
    end
  end

  // Sums and counts including the current stage-2 sample, so a dump can
  // publish them in the same cycle the closing trigger arrives.
  always_comb begin
    sum_x        = acc_x + ACC_W'(px);
    sum_y        = acc_y + ACC_W'(py);
    cnt_next     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    cnt_ovf_next = cnt_ovf | (cnt == '1);
    per_next     = {1'b0, per} + (PER_W+1)'(1);
    window_done  = s2_trig && (per_next == {1'b0, n_lat});
  end

  lock_sat_shift #(.ACC_W(ACC_W)) u_sat_x (
    .din  (sum_x),
    .shift(sh_lat),
    .dout (qx),
    .clip (clip_x)
  );

  lock_sat_shift #(.ACC_W(ACC_W)) u_sat_y (
    .din  (sum_y),
    .shift(sh_lat),
    .dout (qy),
    .clip (clip_y)
  );

  // Stage 3: window FSM and accumulators. en is checked before the state so
  // that dropping it overrides a dump arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      acc_x     <= '0;
      acc_y     <= '0;
      cnt       <= '0;
      cnt_ovf   <= 1'b0;
      per       <= '0;
      n_lat     <= PER_W'(1);
      sh_lat    <= '0;
      x_out     <= '0;
      y_out     <= '0;
      x_sum     <= '0;
      y_sum     <= '0;
      samp_cnt  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!en) begin
        state    <= ST_IDLE;
        acc_x    <= '0;
        acc_y    <= '0;
        cnt      <= '0;
        cnt_ovf  <= 1'b0;
        per      <= '0;
        samp_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM: begin
            if (s2_trig) begin
              state   <= ST_ACC;
              acc_x   <= '0;
              acc_y   <= '0;
              cnt     <= '0;
              cnt_ovf <= 1'b0;
              per     <= '0;
              n_lat   <= (n_periods == '0) ? PER_W'(1) : n_periods;
              sh_lat  <= shift;
            end
          end
          ST_ACC: begin
            if (window_done) begin
              x_sum     <= sum_x;
              y_sum     <= sum_y;
              x_out     <= qx;
              y_out     <= qy;
              samp_cnt  <= cnt_next;
              out_valid <= 1'b1;
              sat_flag  <= cnt_ovf_next | clip_x | clip_y;
              acc_x     <= '0;
              acc_y     <= '0;
              cnt       <= '0;
              cnt_ovf   <= 1'b0;
              per       <= '0;
              n_lat     <= (n_periods == '0) ? PER_W'(1) : n_periods;
              sh_lat    <= shift;
            end else begin
              acc_x   <= sum_x;
              acc_y   <= sum_y;
              cnt     <= cnt_next;
              cnt_ovf <= cnt_ovf_next;
              if (s2_trig) per <= per_next[PER_W-1:0];
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lock_in_demod_acc.sv
// Directed self-checking bench for lock_in_demod_acc.
module tb_lock_in_demod_acc;

  localparam int unsigned ACC_W = 48;
  localparam int unsigned CNT_W = 24;

  logic                     clk;
  logic                     rstn;
  logic                     en;
  logic signed [13:0]       sig_in, ref_x, ref_y;
  logic                     harmonic_trig;
  logic        [7:0]        n_periods;
  logic        [5:0]        shift;
  logic signed [13:0]       x_out, y_out;
  logic signed [ACC_W-1:0]  x_sum, y_sum;
  logic        [CNT_W-1:0]  samp_cnt;
  logic                     out_valid;
  logic                     sat_flag;

  lock_in_demod_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .sig_in       (sig_in),
    .ref_x        (ref_x),
    .ref_y        (ref_y),
    .harmonic_trig(harmonic_trig),
    .n_periods    (n_periods),
    .shift        (shift),
    .x_out        (x_out),
    .y_out        (y_out),
    .x_sum        (x_sum),
    .y_sum        (y_sum),
    .samp_cnt     (samp_cnt),
    .out_valid    (out_valid),
    .sat_flag     (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Captures taken on every out_valid during a run: iteration index and outputs.
  int     vq[$];
  longint xsq[$];
  longint ysq[$];
  int     xoq[$];
  int     yoq[$];
  int     scq[$];
  int     satq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    harmonic_trig = 1'b0;
    repeat (n) step();
  endtask

  // Drives en=1 and a trigger on the last sample of every period; optional
  // mid-run events are scheduled by iteration index (-1 = never).
  task automatic run(input int period, input int ncyc,
                     input int en_off_at, input int en_on_at, input int rst_at,
                     input int n_at, input int n_val, input int sh_at, input int sh_val);
    vq.delete(); xsq.delete(); ysq.delete(); xoq.delete();
    yoq.delete(); scq.delete(); satq.delete();
    en = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (i == en_off_at) en = 1'b0;
      if (i == en_on_at) en = 1'b1;
      rstn = (rst_at >= 0 && i >= rst_at && i < rst_at + 5) ? 1'b0 : 1'b1;
      if (i == n_at) n_periods = n_val[7:0];
      if (i == sh_at) shift = sh_val[5:0];
      harmonic_trig = ((i % period) == period - 1);
      step();
      if (out_valid === 1'b1) begin
        vq.push_back(i);
        xsq.push_back(longint'(x_sum));
        ysq.push_back(longint'(y_sum));
        xoq.push_back(int'(x_out));
        yoq.push_back(int'(y_out));
        scq.push_back(int'(samp_cnt));
        satq.push_back(int'(sat_flag));
      end
    end
    harmonic_trig = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    rstn = 1'b0; en = 1'b0; harmonic_trig = 1'b0;
    sig_in = 14'sd1000; ref_x = 14'sd1000; ref_y = 14'sd1000;
    n_periods = 8'd1; shift = 6'd0;
    repeat (5) step();
    tests++; if (x_out !== 14'sd0) begin fails++; $display("FAIL reset_x_out: got %0d, expected 0", x_out); end
    tests++; if (y_out !== 14'sd0) begin fails++; $display("FAIL reset_y_out: got %0d, expected 0", y_out); end
    tests++; if (x_sum !== '0) begin fails++; $display("FAIL reset_x_sum: got %0d, expected 0", x_sum); end
    tests++; if (y_sum !== '0) begin fails++; $display("FAIL reset_y_sum: got %0d, expected 0", y_sum); end
    tests++; if (samp_cnt !== '0) begin fails++; $display("FAIL reset_samp_cnt: got %0d, expected 0", samp_cnt); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat_flag: got %b, expected 0", sat_flag); end
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      harmonic_trig = (i % 3 == 2);
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    harmonic_trig = 1'b0;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL idle_no_valid: got strobe, expected none"); end
    tests++; if (x_sum !== '0) begin fails++; $display("FAIL idle_x_sum: got %0d, expected 0", x_sum); end
  endtask

  task automatic test_dc();
    sig_in = 14'sd1000; ref_x = 14'sd8191; ref_y = 14'sd0;
    n_periods = 8'd1; shift = 6'd24;
    idle(5);
    run(4096, 8196, -1, -1, -1, -1, 0, -1, 0);
    tests++; if (vq.size() != 1) begin fails++; $display("FAIL dc_valid_count: got %0d, expected 1", vq.size()); end
    if (vq.size() >= 1) begin
      tests++; if (vq[0] != 8193) begin fails++; $display("FAIL dc_latency: strobe at %0d, expected 8193", vq[0]); end
      tests++; if (xsq[0] != 64'sd33550336000) begin fails++; $display("FAIL dc_x_sum: got %0d, expected 33550336000", xsq[0]); end
      tests++; if (xoq[0] != 1999) begin fails++; $display("FAIL dc_x_out: got %0d, expected 1999", xoq[0]); end
      tests++; if (ysq[0] != 0) begin fails++; $display("FAIL dc_y_sum: got %0d, expected 0", ysq[0]); end
      tests++; if (scq[0] != 4096) begin fails++; $display("FAIL dc_samp_cnt: got %0d, expected 4096", scq[0]); end
      tests++; if (satq[0] != 0) begin fails++; $display("FAIL dc_sat_flag: got %0d, expected 0", satq[0]); end
    end
    tests++; if (longint'(x_sum) != 64'sd33550336000) begin fails++; $display("FAIL dc_hold: got %0d, expected 33550336000", x_sum); end
  endtask

  task automatic test_multi_period();
    sig_in = -14'sd500; ref_x = 14'sd100; ref_y = -14'sd200;
    n_periods = 8'd3; shift = 6'd12;
    idle(5);
    run(100, 1003, -1, -1, -1, -1, 0, -1, 0);
    tests++; if (vq.size() != 3) begin fails++; $display("FAIL multi_valid_count: got %0d, expected 3", vq.size()); end
    for (int k = 0; k < vq.size() && k < 3; k++) begin
      tests++; if (vq[k] != 401 + 300 * k) begin fails++; $display("FAIL multi_strobe_%0d: at %0d, expected %0d", k, vq[k], 401 + 300 * k); end
      tests++; if (scq[k] != 300) begin fails++; $display("FAIL multi_samp_cnt_%0d: got %0d, expected 300", k, scq[k]); end
    end
    if (vq.size() >= 1) begin
      tests++; if (xsq[0] != -64'sd15000000) begin fails++; $display("FAIL multi_x_sum: got %0d, expected -15000000", xsq[0]); end
      tests++; if (ysq[0] != 64'sd30000000) begin fails++; $display("FAIL multi_y_sum: got %0d, expected 30000000", ysq[0]); end
      tests++; if (xoq[0] != -3663) begin fails++; $display("FAIL multi_x_out: got %0d, expected -3663", xoq[0]); end
      tests++; if (yoq[0] != 7324) begin fails++; $display("FAIL multi_y_out: got %0d, expected 7324", yoq[0]); end
      tests++; if (satq[0] != 0) begin fails++; $display("FAIL multi_sat_flag: got %0d, expected 0", satq[0]); end
    end
  endtask

  task automatic test_saturation();
    sig_in = 14'sd8191; ref_x = 14'sd8191; ref_y = -14'sd8191;
    n_periods = 8'd1; shift = 6'd0;
    idle(5);
    // shift changes mid first window: must only affect the second window
    run(4096, 12292, -1, -1, -1, -1, 0, 6000, 30);
    tests++; if (vq.size() != 2) begin fails++; $display("FAIL sat_valid_count: got %0d, expected 2", vq.size()); end
    if (vq.size() >= 2) begin
      tests++; if (xsq[0] != 64'sd274810802176) begin fails++; $display("FAIL sat_x_sum: got %0d, expected 274810802176", xsq[0]); end
      tests++; if (xoq[0] != 8191) begin fails++; $display("FAIL sat_x_out: got %0d, expected 8191", xoq[0]); end
      tests++; if (yoq[0] != -8192) begin fails++; $display("FAIL sat_y_out: got %0d, expected -8192", yoq[0]); end
      tests++; if (satq[0] != 1) begin fails++; $display("FAIL sat_flag_set: got %0d, expected 1", satq[0]); end
      tests++; if (vq[1] != 12289) begin fails++; $display("FAIL sat_second_strobe: at %0d, expected 12289", vq[1]); end
      tests++; if (xoq[1] != 255) begin fails++; $display("FAIL sat_x_out_shift30: got %0d, expected 255", xoq[1]); end
      tests++; if (yoq[1] != -256) begin fails++; $display("FAIL sat_y_out_shift30: got %0d, expected -256", yoq[1]); end
      tests++; if (satq[1] != 0) begin fails++; $display("FAIL sat_flag_clear: got %0d, expected 0", satq[1]); end
    end
  endtask

  task automatic test_n_zero();
    sig_in = 14'sd3; ref_x = -14'sd7; ref_y = 14'sd5;
    n_periods = 8'd0; shift = 6'd0;
    idle(5);
    run(10, 33, -1, -1, -1, -1, 0, -1, 0);
    tests++; if (vq.size() != 2) begin fails++; $display("FAIL nzero_valid_count: got %0d, expected 2", vq.size()); end
    if (vq.size() >= 2) begin
      tests++; if (vq[0] != 21 || vq[1] != 31) begin fails++; $display("FAIL nzero_strobes: at %0d,%0d, expected 21,31", vq[0], vq[1]); end
      tests++; if (scq[0] != 10) begin fails++; $display("FAIL nzero_samp_cnt: got %0d, expected 10", scq[0]); end
      tests++; if (xsq[1] != -210) begin fails++; $display("FAIL nzero_x_sum: got %0d, expected -210", xsq[1]); end
      tests++; if (yoq[1] != 150) begin fails++; $display("FAIL nzero_y_out: got %0d, expected 150", yoq[1]); end
    end
  endtask

  task automatic test_back_to_back();
    sig_in = 14'sd3; ref_x = -14'sd7; ref_y = 14'sd5;
    n_periods = 8'd3; shift = 6'd0;
    idle(5);
    run(1, 12, -1, -1, -1, -1, 0, -1, 0);
    tests++; if (vq.size() != 3) begin fails++; $display("FAIL b2b_valid_count: got %0d, expected 3", vq.size()); end
    for (int k = 0; k < vq.size() && k < 3; k++) begin
      tests++; if (vq[k] != 5 + 3 * k) begin fails++; $display("FAIL b2b_strobe_%0d: at %0d, expected %0d", k, vq[k], 5 + 3 * k); end
      tests++; if (scq[k] != 3 || xsq[k] != -63) begin fails++; $display("FAIL b2b_window_%0d: cnt %0d sum %0d, expected cnt 3 sum -63", k, scq[k], xsq[k]); end
    end
  endtask

  task automatic test_abort_en();
    sig_in = 14'sd10; ref_x = 14'sd20; ref_y = 14'sd30;
    n_periods = 8'd1; shift = 6'd0;
    idle(5);
    run(200, 610, 300, 320, -1, -1, 0, -1, 0);
    tests++; if (vq.size() != 1) begin fails++; $display("FAIL abort_en_count: got %0d, expected 1", vq.size()); end
    if (vq.size() >= 1) begin
      tests++; if (vq[0] != 601) begin fails++; $display("FAIL abort_en_strobe: at %0d, expected 601", vq[0]); end
      tests++; if (scq[0] != 200) begin fails++; $display("FAIL abort_en_samp_cnt: got %0d, expected 200", scq[0]); end
    end
  endtask

  task automatic test_abort_rst();
    sig_in = 14'sd10; ref_x = 14'sd20; ref_y = 14'sd30;
    n_periods = 8'd1; shift = 6'd0;
    idle(5);
    run(200, 610, -1, -1, 300, -1, 0, -1, 0);
    tests++; if (vq.size() != 1) begin fails++; $display("FAIL abort_rst_count: got %0d, expected 1", vq.size()); end
    if (vq.size() >= 1) begin
      tests++; if (vq[0] != 601) begin fails++; $display("FAIL abort_rst_strobe: at %0d, expected 601", vq[0]); end
      tests++; if (xsq[0] != 40000) begin fails++; $display("FAIL abort_rst_x_sum: got %0d, expected 40000", xsq[0]); end
    end
  endtask

  task automatic test_en_priority();
    sig_in = 14'sd10; ref_x = 14'sd20; ref_y = 14'sd30;
    n_periods = 8'd1; shift = 6'd0;
    idle(5);
    // closing trigger at 199 reaches the FSM at 201, the cycle en drops
    run(100, 206, 201, -1, -1, -1, 0, -1, 0);
    tests++; if (vq.size() != 0) begin fails++; $display("FAIL en_priority: got %0d strobes, expected 0", vq.size()); end
  endtask

  task automatic test_mid_change();
    sig_in = 14'sd1; ref_x = 14'sd1; ref_y = 14'sd1;
    n_periods = 8'd2; shift = 6'd0;
    idle(5);
    run(50, 410, -1, -1, -1, 70, 5, -1, 0);
    tests++; if (vq.size() != 2) begin fails++; $display("FAIL midchg_count: got %0d, expected 2", vq.size()); end
    if (vq.size() >= 2) begin
      tests++; if (vq[0] != 151) begin fails++; $display("FAIL midchg_first: at %0d, expected 151", vq[0]); end
      tests++; if (scq[0] != 100) begin fails++; $display("FAIL midchg_first_cnt: got %0d, expected 100", scq[0]); end
      tests++; if (vq[1] != 401) begin fails++; $display("FAIL midchg_second: at %0d, expected 401", vq[1]); end
      tests++; if (scq[1] != 250) begin fails++; $display("FAIL midchg_second_cnt: got %0d, expected 250", scq[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_multi_period();
    test_saturation();
    test_n_zero();
    test_back_to_back();
    test_abort_en();
    test_abort_rst();
    test_en_priority();
    test_mid_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
